// File: rtl/bin_to_bcd_ascii_pkg.sv
// Shared definitions for the bin_to_bcd_ascii converter.
//   ASCII_ZERO : character code of '0', OR-ed with each BCD digit to form its character
//   state_t    : converter FSM encoding (IDLE / SHIFT / DONE)
//   cnt_width  : width of a bit counter that must hold the value 'width' itself
package bin_to_bcd_ascii_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bin_to_bcd_ascii_if.sv
// Handshake and data bundle between a requester and the bin_to_bcd_ascii converter.
//   start     : request conversion of bin_in (requester -> converter)
//   bin_in    : WIDTH-bit binary value       (requester -> converter)
//   busy      : conversion in progress       (converter -> requester)
//   done      : one-cycle result-valid pulse (converter -> requester)
//   bcd_out   : packed BCD, units in [3:0]   (converter -> requester)
//   ascii_out : ASCII digits, units in [7:0] (converter -> requester)
// master = requester side, slave = converter side.
interface bin_to_bcd_ascii_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [8*DIGITS-1:0]   ascii_out;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out,
    input  ascii_out
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out,
    output ascii_out
  );

endinterface

// File: rtl/bin_to_bcd_ascii_dd_add3.sv
// dd_add3: double-dabble correction cell for one BCD digit.
//   din  : 4-bit digit before correction (0..9 in legal operation)
//   dout : din + 3 when din >= 5, otherwise din unchanged (max 12, fits in 4 bits)
module dd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Pre-adding 3 makes a digit >= 5 carry into the next digit on the following shift.
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_ascii.sv
// bin_to_bcd_ascii: iterative shift-and-add-3 binary to BCD/ASCII converter.
// One input bit is consumed per clock; a result appears WIDTH+1 cycles after start.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : converter side of bin_to_bcd_ascii_if (start/bin_in in; busy/done/bcd_out/ascii_out out)
module bin_to_bcd_ascii
  import bin_to_bcd_ascii_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  bin_to_bcd_ascii_if.slave     bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  // Too few digits would silently lose the top of the decimal result.
  if ((10 ** DIGITS) <= ((2 ** WIDTH) - 1)) begin : g_digits_check
    $error("bin_to_bcd_ascii: DIGITS too small for WIDTH");
  end

  state_t                state;
  state_t                state_nx;
  logic [WIDTH-1:0]      shift_q;
  logic [4*DIGITS-1:0]   scratch_q;
  logic [4*DIGITS-1:0]   corrected;
  logic [4*DIGITS+WIDTH-1:0] shifted;
  logic [CW-1:0]         cnt;
  logic [4*DIGITS-1:0]   bcd_q;
  logic [8*DIGITS-1:0]   ascii_q;
  logic                  accept;
  logic                  last_bit;

  // One correction cell per digit; the sequencing reuses them every cycle.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    dd_add3 u_add3 (
      .din  (scratch_q[4*g +: 4]),
      .dout (corrected[4*g +: 4])
    );
  end

  // Correction happens before the shift, so the shift takes the corrected digits.
  // The bit shifted out of the top digit is always zero for a legal WIDTH/DIGITS pair.
  assign shifted  = {corrected, shift_q} << 1;
  assign accept   = bus.start && ((state == IDLE) || (state == DONE));
  assign last_bit = (cnt == CNT_LAST);

  // Next-state logic: DONE behaves like IDLE for a new request, enabling back-to-back runs.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? SHIFT : IDLE;
      SHIFT:   state_nx = last_bit ? DONE : SHIFT;
      DONE:    state_nx = accept ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, shift registers, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt       <= '0;
      bcd_q     <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        ascii_q[8*i +: 8] <= ASCII_ZERO;
      end
    end else begin
      state <= state_nx;
      if (accept) begin
        shift_q   <= bus.bin_in;
        scratch_q <= '0;
        cnt       <= CNT_LOAD;
      end else if (state == SHIFT) begin
        {scratch_q, shift_q} <= shifted;
        cnt                  <= cnt - CNT_LAST;
        // Final shift: publish the finished digits straight from the shift result.
        if (last_bit) begin
          bcd_q <= shifted[4*DIGITS+WIDTH-1 -: 4*DIGITS];
          for (int i = 0; i < DIGITS; i++) begin
            ascii_q[8*i +: 8] <= ASCII_ZERO | {4'h0, shifted[WIDTH+4*i +: 4]};
          end
        end
      end
    end
  end

  assign bus.busy      = (state == SHIFT);
  assign bus.done      = (state == DONE);
  assign bus.bcd_out   = bcd_q;
  assign bus.ascii_out = ascii_q;

endmodule

// File: tb/tb_bin_to_bcd_ascii.sv
// tb_bin_to_bcd_ascii: self-checking bench for bin_to_bcd_ascii (WIDTH=8, DIGITS=3).
// Expected digits come from decimal arithmetic on the input value.
module tb_bin_to_bcd_ascii;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bin_to_bcd_ascii_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_ascii #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference digits: hundreds, tens, units by plain division.
  function automatic logic [11:0] modelBcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  function automatic logic [23:0] modelAscii(input int v);
    logic [7:0] h, t, u;
    h = 8'(48 + v / 100);
    t = 8'(48 + (v / 10) % 10);
    u = 8'(48 + v % 10);
    return {h, t, u};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive request inputs after a falling edge so they are stable at the next rising edge.
  task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] v);
    bus.start  = s;
    bus.bin_in = v;
    @(negedge clk);
  endtask

  // One full conversion; optionally spray ignored start pulses while busy.
  task automatic convertOne(input int v, input string tag, input bit noise);
    int busy_cycles;
    int waited;
    busy_cycles = 0;
    waited      = 0;
    applyStimulus(1'b1, WIDTH'(v));
    bus.start  = 1'b0;
    bus.bin_in = WIDTH'($urandom);
    while (bus.done !== 1'b1 && waited < 20) begin
      if (bus.busy === 1'b1) busy_cycles++;
      waited++;
      if (noise) begin
        bus.start  = 1'($urandom_range(0, 1));
        bus.bin_in = WIDTH'($urandom);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    checkOutput({tag, " busy_cycles"}, 32'(busy_cycles), 32'd8);
    checkOutput({tag, " done"}, 32'(bus.done), 32'd1);
    checkOutput({tag, " bcd"}, 32'(bus.bcd_out), 32'(modelBcd(v)));
    checkOutput({tag, " ascii"}, 32'(bus.ascii_out), 32'(modelAscii(v)));
    @(negedge clk);
    checkOutput({tag, " done_pulse_end"}, 32'(bus.done), 32'd0);
    checkOutput({tag, " bcd_hold"}, 32'(bus.bcd_out), 32'(modelBcd(v)));
  endtask

  initial begin
    int vals3[4];
    int waited;
    int gap;
    int idx;
    int got;
    int exp_q[$];
    int ev;
    bit done_seen;

    bus.start  = 1'b0;
    bus.bin_in = '0;

    // Reset state
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset bcd", 32'(bus.bcd_out), 32'h000);
    checkOutput("reset ascii", 32'(bus.ascii_out), 32'h303030);
    rst = 1'b0;
    @(negedge clk);

    // Maximum input
    convertOne(255, "v255", 1'b0);

    // Boundary values, with ignored start pulses during busy
    vals3 = '{0, 9, 99, 100};
    foreach (vals3[i]) convertOne(vals3[i], $sformatf("v%0d", vals3[i]), 1'b1);

    // Back-to-back with start held high: 42 then 17, second value must not leak into first
    applyStimulus(1'b1, 8'd42);
    bus.bin_in = 8'd17;
    waited = 0;
    while (bus.done !== 1'b1 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    checkOutput("b2b first latency", 32'(waited), 32'd8);
    checkOutput("b2b first bcd", 32'(bus.bcd_out), 32'h042);
    checkOutput("b2b first ascii", 32'(bus.ascii_out), 32'h303432);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bin_in = 8'd99;
    gap = 1;
    while (bus.done !== 1'b1 && gap < 20) begin
      gap++;
      @(negedge clk);
    end
    checkOutput("b2b period", 32'(gap), 32'd9);
    checkOutput("b2b second bcd", 32'(bus.bcd_out), 32'h017);
    checkOutput("b2b second ascii", 32'(bus.ascii_out), 32'h303137);
    @(negedge clk);

    // Reset four cycles into converting 200
    applyStimulus(1'b1, 8'd200);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort bcd", 32'(bus.bcd_out), 32'h000);
    checkOutput("abort ascii", 32'(bus.ascii_out), 32'h303030);
    done_seen = 1'b0;
    repeat (12) begin
      if (bus.done === 1'b1) done_seen = 1'b1;
      @(negedge clk);
    end
    checkOutput("abort no_done", 32'(done_seen), 32'd0);
    convertOne(7, "after_abort v7", 1'b0);

    // Random single conversions with noise
    repeat (10) convertOne(int'($urandom_range(0, 255)), "random", 1'b1);

    // Full sweep 0..255 back-to-back; bin_in is scrambled while busy
    bus.start  = 1'b1;
    bus.bin_in = 8'd0;
    exp_q.push_back(0);
    idx = 1;
    got = 0;
    waited = 0;
    @(negedge clk);
    while (got < 256 && waited < 256 * 9 + 50) begin
      if (bus.done === 1'b1) begin
        ev = exp_q.pop_front();
        checkOutput($sformatf("sweep bcd %0d", ev), 32'(bus.bcd_out), 32'(modelBcd(ev)));
        checkOutput($sformatf("sweep ascii %0d", ev), 32'(bus.ascii_out), 32'(modelAscii(ev)));
        got++;
        if (idx < 256) begin
          bus.bin_in = WIDTH'(idx);
          exp_q.push_back(idx);
          idx++;
        end else begin
          bus.start = 1'b0;
        end
      end else begin
        bus.bin_in = WIDTH'($urandom);
      end
      waited++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    checkOutput("sweep results", 32'(got), 32'd256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
